// File: rtl/mfp_eic_cpu_stub.sv
// CPU-side stand-in for a MIPS32 core on the EIC interface: takes interrupts,
// raises IPL, nests on higher priority and returns on handler end or eret.
module mfp_eic_cpu_stub #(
   parameter int STACK_DEPTH    = 4,
   parameter int HANDLER_CYCLES = 16,
   parameter int ACK_DELAY      = 2
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        ie,
   input  logic        eret,
   input  logic        EIC_Present,
   input  logic [7:0]  EIC_Interrupt,
   input  logic [5:0]  EIC_Vector,
   input  logic [16:0] EIC_Offset,
   input  logic [3:0]  EIC_ShadowSet,
   output logic        EIC_IAck,
   output logic [7:0]  EIC_IPL,
   output logic [5:0]  EIC_IVN,
   output logic [16:0] EIC_ION,
   output logic        busy,
   output logic [3:0]  depth,
   output logic [15:0] taken_cnt,
   output logic        nest_full
);

   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int SLOTS = 1 << IDX_W;
   localparam logic [3:0]  MAX_DEPTH = 4'(STACK_DEPTH);
   localparam logic [15:0] SYNC_LAST = 16'(ACK_DELAY - 1);
   localparam logic [15:0] HC_LOAD   = 16'(HANDLER_CYCLES);

   typedef enum logic [1:0] {IDLE, ACK, HANDLER} state_t;

   typedef struct packed {
      logic [7:0]  ipl;
      logic [5:0]  ivn;
      logic [16:0] ion;
      logic [15:0] cnt;
   } ctx_t;

   state_t      state_q, state_d;
   logic [15:0] sync_q, sync_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  ipl_q, ipl_d;
   logic [5:0]  ivn_q, ivn_d;
   logic [16:0] ion_q, ion_d;
   logic [3:0]  depth_q, depth_d;
   logic [15:0] taken_q, taken_d;
   logic        nest_full_q, nest_full_d;
   ctx_t        stack_q [SLOTS];
   ctx_t        stack_d [SLOTS];

   logic             req_ok, cond, blocked, sync_hit, done, take;
   logic [IDX_W-1:0] push_idx, pop_idx;
   logic             unused_shadow;

   assign unused_shadow = ^EIC_ShadowSet;

   assign req_ok   = ie & EIC_Present & (EIC_Interrupt > ipl_q);
   assign cond     = req_ok & (depth_q < MAX_DEPTH);
   assign blocked  = req_ok & (depth_q == MAX_DEPTH);
   assign sync_hit = (sync_q == SYNC_LAST);
   assign done     = (state_q == HANDLER) & ((cnt_q == 16'd1) | eret);
   assign take     = (state_q != ACK) & ~done & cond & sync_hit;
   assign push_idx = IDX_W'(depth_q - 4'd1);
   assign pop_idx  = IDX_W'(depth_q - 4'd2);

   always_ff @(posedge CLK) begin
      if (!RESETn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (take) state_d = ACK;
         ACK:     state_d = HANDLER;
         HANDLER: begin
            if (done) begin
               if (depth_q == 4'd1) state_d = IDLE;
            end else if (take) begin
               state_d = ACK;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The preempted handler's count is saved already decremented for this
   // cycle, so it runs exactly HANDLER_CYCLES cycles in total across nesting.
   always_comb begin
      sync_d      = '0;
      cnt_d       = cnt_q;
      ipl_d       = ipl_q;
      ivn_d       = ivn_q;
      ion_d       = ion_q;
      depth_d     = depth_q;
      taken_d     = taken_q;
      stack_d     = stack_q;
      nest_full_d = nest_full_q | ((state_q != ACK) & blocked);
      if ((state_q != ACK) && !done && cond && !sync_hit) sync_d = sync_q + 16'd1;
      if (take) begin
         if (depth_q != 4'd0)
            stack_d[push_idx] = '{ipl: ipl_q, ivn: ivn_q, ion: ion_q, cnt: cnt_q - 16'd1};
         ipl_d   = EIC_Interrupt;
         ivn_d   = EIC_Vector;
         ion_d   = EIC_Offset;
         depth_d = depth_q + 4'd1;
         taken_d = taken_q + 16'd1;
      end else if (state_q == ACK) begin
         cnt_d = HC_LOAD;
      end else if (done) begin
         depth_d = depth_q - 4'd1;
         if (depth_q == 4'd1) begin
            ipl_d = '0;
            ivn_d = '0;
            ion_d = '0;
            cnt_d = '0;
         end else begin
            ipl_d = stack_q[pop_idx].ipl;
            ivn_d = stack_q[pop_idx].ivn;
            ion_d = stack_q[pop_idx].ion;
            cnt_d = stack_q[pop_idx].cnt;
         end
      end else if (state_q == HANDLER) begin
         cnt_d = cnt_q - 16'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         sync_q      <= '0;
         cnt_q       <= '0;
         ipl_q       <= '0;
         ivn_q       <= '0;
         ion_q       <= '0;
         depth_q     <= '0;
         taken_q     <= '0;
         nest_full_q <= 1'b0;
         for (int i = 0; i < SLOTS; i++) stack_q[i] <= '0;
      end else begin
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         ipl_q       <= ipl_d;
         ivn_q       <= ivn_d;
         ion_q       <= ion_d;
         depth_q     <= depth_d;
         taken_q     <= taken_d;
         nest_full_q <= nest_full_d;
         stack_q     <= stack_d;
      end
   end

   always_comb begin
      EIC_IAck  = (state_q == ACK);
      EIC_IPL   = ipl_q;
      EIC_IVN   = ivn_q;
      EIC_ION   = ion_q;
      busy      = (depth_q != 4'd0);
      depth     = depth_q;
      taken_cnt = taken_q;
      nest_full = nest_full_q;
   end

endmodule
